// File: rtl/seg7_scan_multi.sv
// Multiplexed 7-segment scanner: per-frame input shadowing, leading-zero
// blanking, per-digit blank/blink, 16-level PWM brightness and a dead cycle
// at the end of every digit slot. Outputs are registered; pin polarity is
// applied after the output registers.
module seg7_scan_multi #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 131072,
    parameter int BLINK_FRAMES = 64,
    parameter bit WEI_ACT_LOW  = 1'b0,
    parameter bit DUAN_ACT_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_blank_en,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     smg_wei,
    output logic [7:0]            smg_duan,
    output logic                  frame_sync
);

    localparam int CW   = $clog2(SCAN_DIV);
    localparam int IW   = $clog2(DIGITS);
    localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int QDIV = SCAN_DIV / 16;
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    // Active-high glyph for one hex nibble, segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
    endfunction

    logic [CW-1:0]       cnt_r;
    logic [QW-1:0]       q_r;
    logic [3:0]          sub_r;
    logic [IW-1:0]       idx_r;
    logic [FW-1:0]       frame_r;
    logic                blink_on_r;

    logic [4*DIGITS-1:0] data_r;
    logic [DIGITS-1:0]   dp_r;
    logic [DIGITS-1:0]   blank_r;
    logic [DIGITS-1:0]   blinkm_r;
    logic                lz_en_r;
    logic [3:0]          bright_r;

    logic [DIGITS-1:0]   wei_r;
    logic [7:0]          duan_r;
    logic                fsync_r;

    logic                slot_end_s;
    logic                frame_end_s;
    logic                frame_start_s;
    logic                q_end_s;
    logic [DIGITS-1:0]   lz_dark_s;
    logic                run_s;
    logic [3:0]          nib_s;
    logic                dark_s;
    logic [DIGITS-1:0]   wei_nxt_s;
    logic [7:0]          duan_nxt_s;

    assign slot_end_s    = (cnt_r == CW'(SCAN_DIV - 1));
    assign frame_end_s   = slot_end_s && (idx_r == IW'(DIGITS - 1));
    assign frame_start_s = (cnt_r == CW'(0)) && (idx_r == IW'(0));
    assign q_end_s       = (q_r == QW'(QDIV - 1));

    // Slot prescaler, PWM sub-step counter and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            q_r   <= '0;
            sub_r <= 4'd0;
            idx_r <= '0;
        end else if (slot_end_s) begin
            cnt_r <= '0;
            q_r   <= '0;
            sub_r <= 4'd0;
            idx_r <= (idx_r == IW'(DIGITS - 1)) ? IW'(0) : idx_r + IW'(1);
        end else begin
            cnt_r <= cnt_r + CW'(1);
            if (q_end_s) begin
                q_r   <= '0;
                sub_r <= sub_r + 4'd1;
            end else begin
                q_r   <= q_r + QW'(1);
            end
        end
    end

    // Frame counter and blink phase, advanced once per completed frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r    <= '0;
            blink_on_r <= 1'b1;
        end else if (frame_end_s) begin
            if (frame_r == FW'(BLINK_FRAMES - 1)) begin
                frame_r    <= '0;
                blink_on_r <= ~blink_on_r;
            end else begin
                frame_r    <= frame_r + FW'(1);
            end
        end
    end

    // Shadow registers, loaded on the edge that enters the frame-start cycle
    // so a whole frame is always drawn from one consistent snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r   <= '0;
            dp_r     <= '0;
            blank_r  <= '0;
            blinkm_r <= '0;
            lz_en_r  <= 1'b0;
            bright_r <= 4'd0;
        end else if (frame_end_s) begin
            data_r   <= data_in;
            dp_r     <= dp_in;
            blank_r  <= blank_in;
            blinkm_r <= blink_mask;
            lz_en_r  <= lz_blank_en;
            bright_r <= bright;
        end
    end

    // Leading-zero run from the top digit; forced-blank digits keep the run going
    always_comb begin
        lz_dark_s = '0;
        run_s     = lz_en_r;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (run_s && blank_r[k]) begin
                lz_dark_s[k] = 1'b1;
            end else if (run_s && (data_r[4*k +: 4] == 4'h0) && !dp_r[k]) begin
                lz_dark_s[k] = 1'b1;
            end else begin
                run_s = 1'b0;
            end
        end
    end

    // Decode the current slot into next-cycle digit select and segments
    always_comb begin
        nib_s  = data_r[{idx_r, 2'b00} +: 4];
        dark_s = blank_r[idx_r]
               | (blinkm_r[idx_r] & ~blink_on_r)
               | lz_dark_s[idx_r]
               | (sub_r > bright_r)
               | slot_end_s;
        if (dark_s) begin
            wei_nxt_s  = '0;
            duan_nxt_s = 8'h00;
        end else begin
            wei_nxt_s  = DIGITS'(1) << idx_r;
            duan_nxt_s = {dp_r[idx_r], glyph(nib_s)};
        end
    end

    // Registered outputs and frame pulse aligned with digit 0's first output cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wei_r   <= '0;
            duan_r  <= 8'h00;
            fsync_r <= 1'b0;
        end else begin
            wei_r   <= wei_nxt_s;
            duan_r  <= duan_nxt_s;
            fsync_r <= frame_start_s;
        end
    end

    assign smg_wei    = wei_r ^ {DIGITS{WEI_ACT_LOW}};
    assign smg_duan   = duan_r ^ {8{DUAN_ACT_LOW}};
    assign frame_sync = fsync_r;

endmodule

// File: tb/tb_seg7_scan_multi.sv
// Bench for seg7_scan_multi (DIGITS=4, SCAN_DIV=16, BLINK_FRAMES=2): a frame-level
// reference model checked every cycle, a vector table, and hand-written
// blink / mid-frame-update / mid-frame-reset sequences. An active-low copy of
// the design runs alongside on the same inputs.
module tb_seg7_scan_multi;

    localparam int D  = 4;
    localparam int SD = 16;
    localparam int BF = 2;
    localparam int FL = D * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic        lz_blank_en = 1'b0;
    logic [3:0]  bright = 4'h0;
    logic [3:0]  wei_h, wei_l;
    logic [7:0]  duan_h, duan_l;
    logic        fs_h, fs_l;

    always #5 clk = ~clk;

    seg7_scan_multi #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
                      .WEI_ACT_LOW(1'b0), .DUAN_ACT_LOW(1'b0)) u_hi (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_mask(blink_mask), .lz_blank_en(lz_blank_en),
        .bright(bright), .smg_wei(wei_h), .smg_duan(duan_h), .frame_sync(fs_h));

    seg7_scan_multi #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
                      .WEI_ACT_LOW(1'b1), .DUAN_ACT_LOW(1'b1)) u_lo (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_mask(blink_mask), .lz_blank_en(lz_blank_en),
        .bright(bright), .smg_wei(wei_l), .smg_duan(duan_l), .frame_sync(fs_l));

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;

    logic [15:0] sh_data;
    logic [3:0]  sh_dp, sh_blank, sh_blinkm, sh_bright;
    logic        sh_lz;
    logic [7:0]  gly [16];

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic [3:0]  bright;
        logic [31:0] duan;
        logic [15:0] lit;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", nm, t, act, exp);
        end
    endtask

    // Reference: what a given scan position since reset should display
    task automatic model_exp(input int s, output logic [3:0] w, output logic [7:0] du,
                             output logic fs);
        int n, p, d, c, sig;
        logic on, lit;
        n   = s / FL;
        p   = s % FL;
        d   = p / SD;
        c   = p % SD;
        on  = ((n / BF) % 2) == 0;
        sig = -1;
        for (int k = 0; k < D; k++)
            if (!sh_blank[k] && (sh_data[4*k +: 4] != 4'h0 || sh_dp[k])) sig = k;
        lit = (c != SD - 1) && (c <= int'(sh_bright)) && !sh_blank[d]
              && !(sh_blinkm[d] && !on) && !(sh_lz && d > 0 && d > sig);
        w   = lit ? 4'(1 << d) : 4'h0;
        du  = lit ? (gly[sh_data[4*d +: 4]] | (sh_dp[d] ? 8'h80 : 8'h00)) : 8'h00;
        fs  = (p == 0);
    endtask

    task automatic step();
        logic [3:0] ew;
        logic [7:0] ed;
        logic ef;
        @(posedge clk);
        model_exp(t, ew, ed, ef);
        if (t % FL == FL - 1) begin
            sh_data = data_in; sh_dp = dp_in; sh_blank = blank_in;
            sh_blinkm = blink_mask; sh_lz = lz_blank_en; sh_bright = bright;
        end
        t++;
        #1;
        chk("wei", {28'h0, wei_h}, {28'h0, ew});
        chk("duan", {24'h0, duan_h}, {24'h0, ed});
        chk("frame_sync", {31'h0, fs_h}, {31'h0, ef});
        chk("wei_lo", {28'h0, wei_l}, {28'h0, ~ew});
        chk("duan_lo", {24'h0, duan_l}, {24'h0, ~ed});
    endtask

    task automatic model_reset();
        t = 0;
        sh_data = 16'h0; sh_dp = 4'h0; sh_blank = 4'h0;
        sh_blinkm = 4'h0; sh_lz = 1'b0; sh_bright = 4'h0;
    endtask

    task automatic chk_dark(input string nm);
        chk({nm, "_wei"}, {28'h0, wei_h}, 32'h0);
        chk({nm, "_duan"}, {24'h0, duan_h}, 32'h0);
        chk({nm, "_fs"}, {31'h0, fs_h}, 32'h0);
        chk({nm, "_wei_lo"}, {28'h0, wei_l}, 32'hF);
        chk({nm, "_duan_lo"}, {24'h0, duan_l}, 32'hFF);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_dark("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Run until the model's next frame start (at least one cycle)
    task automatic align();
        step();
        while (t % FL != 0) step();
    endtask

    initial begin
        int cnt;
        int exp_blink [6];
        logic [7:0] seen [4];
        int litc [4];

        gly = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        vt[0] = '{16'h1A3F, 4'h0, 4'h0, 1'b0, 4'hF, 32'h06774F71, 16'hFFFF};
        vt[1] = '{16'h0005, 4'h0, 4'h0, 1'b1, 4'hF, 32'h0000006D, 16'h000F};
        vt[2] = '{16'h0005, 4'h4, 4'h0, 1'b1, 4'hF, 32'h00BF3F6D, 16'h0FFF};
        vt[3] = '{16'h1A3F, 4'h0, 4'h0, 1'b0, 4'h0, 32'h06774F71, 16'h1111};
        vt[4] = '{16'h1A3F, 4'h0, 4'h0, 1'b0, 4'h7, 32'h06774F71, 16'h8888};
        vt[5] = '{16'h1234, 4'h0, 4'h2, 1'b0, 4'hF, 32'h065B0066, 16'hFF0F};
        vt[6] = '{16'h0100, 4'h0, 4'h4, 1'b1, 4'hF, 32'h0000003F, 16'h000F};
        exp_blink = '{1, 15, 0, 0, 15, 15};
        model_reset();

        // Power-on reset, then blink sequence counted from the first frame
        data_in = 16'h1A3F; bright = 4'hF; blink_mask = 4'b0001;
        #3;
        chk_dark("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int f = 0; f < 6; f++) begin
            cnt = 0;
            for (int i = 0; i < FL; i++) begin
                step();
                if (wei_h == 4'b0001) cnt++;
            end
            chk("blink_d0_lit", cnt, exp_blink[f]);
        end
        blink_mask = 4'h0;

        // Vector table: one latched frame per record
        for (int v = 0; v < 7; v++) begin
            data_in = vt[v].data; dp_in = vt[v].dp; blank_in = vt[v].blank;
            lz_blank_en = vt[v].lz; bright = vt[v].bright;
            align();
            for (int k = 0; k < D; k++) begin seen[k] = 8'h00; litc[k] = 0; end
            for (int i = 0; i < FL; i++) begin
                step();
                if (wei_h != 4'h0) begin
                    litc[i / SD]++;
                    seen[i / SD] = duan_h;
                end
            end
            for (int k = 0; k < D; k++) begin
                chk($sformatf("vec%0d_duan%0d", v, k), {24'h0, seen[k]},
                    {24'h0, vt[v].duan[8*k +: 8]});
                chk($sformatf("vec%0d_lit%0d", v, k), litc[k],
                    {28'h0, vt[v].lit[4*k +: 4]});
            end
        end

        // Mid-frame data change must wait for the next frame
        data_in = 16'h1A3F; dp_in = 4'h0; blank_in = 4'h0; lz_blank_en = 1'b0; bright = 4'hF;
        align();
        align();
        repeat (40) step();
        data_in = 16'h2222;
        repeat (11) step();
        chk("hold_d3", {24'h0, duan_h}, 32'h06);
        while (t % FL != 0) step();
        repeat (51) step();
        chk("new_d3", {24'h0, duan_h}, 32'h5B);

        // Reset asserted in the middle of the digit 2 slot
        align();
        repeat (36) step();
        #2;
        do_reset();
        step();
        chk("post_rst_d0", {28'h0, wei_h}, 32'h1);

        // Randomized stimulus, changing inputs at arbitrary points in the frame
        for (int i = 0; i < 1600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                data_in     = 16'($urandom);
                dp_in       = 4'($urandom);
                blank_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                blink_mask  = 4'($urandom);
                lz_blank_en = 1'($urandom);
                bright      = 4'($urandom);
                if ($urandom_range(0, 3) == 0) data_in[15:8] = 8'h00;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
